// File: rtl/ofmap_rlc_compressor_pkg.sv
// Shared types and constants for the ofmap zero run-length compressor.
package ofmap_rlc_compressor_pkg;

    localparam int RUN_W       = 5;
    localparam int LVL_W       = 8;
    localparam int RLC_PAIRS   = 4;
    localparam int RLC_MAX_RUN = 31;
    localparam int IN_BYTES    = 16;
    localparam int CNT_W       = 5;

    typedef struct packed {
        logic [RUN_W-1:0] run;
        logic [LVL_W-1:0] level;
    } RLC_PAIR;

    typedef struct packed {
        logic                    last;
        logic [2:0]              npairs;
        logic [7:0]              rsvd;
        RLC_PAIR [RLC_PAIRS-1:0] pairs;
    } RLC_WORD;

    typedef enum logic [1:0] {
        ACTIVE,
        FLUSH_RUN,
        FLUSH_WORD
    } COMPRESSOR_STATE;

endpackage

// File: rtl/ofmap_rlc_compressor_if.sv
// Byte-offer input side and packed-word output stream of the compressor.
interface ofmap_rlc_compressor_if;
    import ofmap_rlc_compressor_pkg::*;

    logic [IN_BYTES-1:0][LVL_W-1:0] outmap_data;
    logic [CNT_W-1:0]               outmap_data_valid_num;
    logic [CNT_W-1:0]               valid_taken_num;
    logic                           frame_done;
    logic [63:0]                    rlc_word;
    logic                           rlc_valid;
    logic                           rlc_ready;

    modport slave (
        input  outmap_data, outmap_data_valid_num, frame_done, rlc_ready,
        output valid_taken_num, rlc_word, rlc_valid
    );

    modport master (
        output outmap_data, outmap_data_valid_num, frame_done, rlc_ready,
        input  valid_taken_num, rlc_word, rlc_valid
    );

endinterface

// File: rtl/ofmap_rlc_compressor_packer.sv
// rlc_word_packer: collects {run,level} pairs into 64-bit words and holds the
// output register until the sink accepts it.
module rlc_word_packer
    import ofmap_rlc_compressor_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    i_pair_valid,
    input  RLC_PAIR i_pair,
    input  logic    i_flush,
    input  logic    i_ready,
    output RLC_WORD o_word,
    output logic    o_valid,
    output logic    o_stall
);

    localparam int SLOT_W = $clog2(RLC_PAIRS);

    logic [SLOT_W-1:0]       r_slot;
    RLC_PAIR [RLC_PAIRS-1:0] r_pairs;
    RLC_PAIR [RLC_PAIRS-1:0] w_pairs;
    RLC_WORD                 r_word;
    logic                    r_valid;
    logic                    w_full;

    assign o_stall = r_valid & ~i_ready;
    assign w_full  = i_pair_valid & (r_slot == SLOT_W'(RLC_PAIRS - 1));
    assign o_word  = r_word;
    assign o_valid = r_valid;

    always_comb begin
        w_pairs = r_pairs;
        if (i_pair_valid) begin
            w_pairs[r_slot] = i_pair;
        end
    end

    // Slots are cleared after every load so a partial word carries zeros in unused slots.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot  <= '0;
            r_pairs <= '0;
            r_word  <= '0;
            r_valid <= 1'b0;
        end else if (!o_stall) begin
            if (w_full) begin
                r_word  <= '{last: 1'b0, npairs: 3'(RLC_PAIRS), rsvd: '0, pairs: w_pairs};
                r_valid <= 1'b1;
                r_slot  <= '0;
                r_pairs <= '0;
            end else if (i_flush) begin
                r_word  <= '{last: 1'b1, npairs: 3'(r_slot), rsvd: '0, pairs: r_pairs};
                r_valid <= 1'b1;
                r_slot  <= '0;
                r_pairs <= '0;
            end else begin
                r_valid <= 1'b0;
                if (i_pair_valid) begin
                    r_pairs <= w_pairs;
                    r_slot  <= r_slot + SLOT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/ofmap_rlc_compressor.sv
// Zero run-length encoder for the ReLU'd ofmap stream, one byte per cycle.
// Optional RLC_COMPRESSOR_STATS_EN adds saturating byte/word counters.
module ofmap_rlc_compressor
    import ofmap_rlc_compressor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    ofmap_rlc_compressor_if.slave bus
`ifdef RLC_COMPRESSOR_STATS_EN
    ,
    output logic [23:0]           stat_bytes_in,
    output logic [15:0]           stat_words_out
`endif
);

    COMPRESSOR_STATE  r_state;
    logic [RUN_W-1:0] r_run;
    logic [LVL_W-1:0] w_byte;
    logic             w_take;
    logic             w_stall;
    logic             w_pair_valid;
    RLC_PAIR          w_pair;
    logic             w_flush;
    RLC_WORD          w_word;
    logic             w_valid;
    logic             w_unused_bytes;

    assign w_byte              = bus.outmap_data[0];
    assign w_unused_bytes      = ^bus.outmap_data[IN_BYTES-1:1];
    assign w_take              = (r_state == ACTIVE) && (bus.outmap_data_valid_num != '0) && !w_stall;
    assign bus.valid_taken_num = {{(CNT_W-1){1'b0}}, w_take};
    assign bus.rlc_word        = w_word;
    assign bus.rlc_valid       = w_valid;

    // A trailing run of N zeros is closed as {N-1, 0}: the last zero rides as the level.
    always_comb begin
        w_pair_valid = 1'b0;
        w_pair       = '0;
        w_flush      = 1'b0;
        case (r_state)
            ACTIVE: begin
                if (w_take && (w_byte != '0)) begin
                    w_pair_valid = 1'b1;
                    w_pair       = '{run: r_run, level: w_byte};
                end else if (w_take && (r_run == RUN_W'(RLC_MAX_RUN))) begin
                    w_pair_valid = 1'b1;
                    w_pair       = '{run: r_run, level: '0};
                end
            end
            FLUSH_RUN: begin
                if (!w_stall && (r_run != '0)) begin
                    w_pair_valid = 1'b1;
                    w_pair       = '{run: r_run - RUN_W'(1), level: '0};
                end
            end
            FLUSH_WORD: w_flush = !w_stall;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ACTIVE;
            r_run   <= '0;
        end else begin
            case (r_state)
                ACTIVE: begin
                    if (w_take) begin
                        if ((w_byte != '0) || (r_run == RUN_W'(RLC_MAX_RUN))) begin
                            r_run <= '0;
                        end else begin
                            r_run <= r_run + RUN_W'(1);
                        end
                        if (bus.frame_done) begin
                            r_state <= FLUSH_RUN;
                        end
                    end
                end
                FLUSH_RUN: begin
                    if (!w_stall) begin
                        r_run   <= '0;
                        r_state <= FLUSH_WORD;
                    end
                end
                FLUSH_WORD: begin
                    if (!w_stall) begin
                        r_state <= ACTIVE;
                    end
                end
                default: r_state <= ACTIVE;
            endcase
        end
    end

    rlc_word_packer u_packer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_pair_valid (w_pair_valid),
        .i_pair       (w_pair),
        .i_flush      (w_flush),
        .i_ready      (bus.rlc_ready),
        .o_word       (w_word),
        .o_valid      (w_valid),
        .o_stall      (w_stall)
    );

`ifdef RLC_COMPRESSOR_STATS_EN
    logic [23:0] r_stat_bytes_in;
    logic [15:0] r_stat_words_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_bytes_in  <= '0;
            r_stat_words_out <= '0;
        end else begin
            if (w_take && (r_stat_bytes_in != '1)) begin
                r_stat_bytes_in <= r_stat_bytes_in + 24'd1;
            end
            if (w_valid && bus.rlc_ready && (r_stat_words_out != '1)) begin
                r_stat_words_out <= r_stat_words_out + 16'd1;
            end
        end
    end

    assign stat_bytes_in  = r_stat_bytes_in;
    assign stat_words_out = r_stat_words_out;
`endif

endmodule

// File: tb/tb_ofmap_rlc_compressor.sv
// Scoreboard bench for ofmap_rlc_compressor; words expected per frame are queued at drive time.
module tb_ofmap_rlc_compressor;

    typedef logic [7:0] byte_q_t[$];

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    bit   rand_ready = 0;
    logic [63:0] exp_q[$];

    ofmap_rlc_compressor_if bus ();

`ifdef RLC_COMPRESSOR_STATS_EN
    logic [23:0] stat_bytes_in;
    logic [15:0] stat_words_out;
`endif

    ofmap_rlc_compressor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus)
`ifdef RLC_COMPRESSOR_STATS_EN
        ,
        .stat_bytes_in  (stat_bytes_in),
        .stat_words_out (stat_words_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // Word monitor: every accepted word is matched against the head of the queue.
    always @(negedge clk) begin
        logic [63:0] exp;
        if (rst_n === 1'b1 && bus.rlc_valid === 1'b1 && bus.rlc_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_word got %h expected none", bus.rlc_word);
            end else begin
                exp = exp_q.pop_front();
                if (bus.rlc_word !== exp) begin
                    errors++;
                    $display("FAIL rlc_word got %h expected %h", bus.rlc_word, exp);
                end
            end
        end
    end

    function automatic logic [63:0] make_word(input bit last, input logic [12:0] p[$]);
        logic [63:0] w;
        w = '0;
        w[63] = last;
        w[62:60] = 3'(p.size());
        for (int k = 0; k < p.size(); k++) w[13*k +: 13] = p[k];
        return w;
    endfunction

    function automatic void model_push(input byte_q_t bytes, input bit close);
        logic [12:0] pairs[$];
        logic [12:0] grp[$];
        int run = 0;
        foreach (bytes[i]) begin
            if (bytes[i] != 8'h00) begin
                pairs.push_back({5'(run), bytes[i]});
                run = 0;
            end else if (run == 31) begin
                pairs.push_back({5'd31, 8'h00});
                run = 0;
            end else begin
                run++;
            end
        end
        if (close && run > 0) pairs.push_back({5'(run - 1), 8'h00});
        while (pairs.size() >= 4) begin
            grp.delete();
            for (int k = 0; k < 4; k++) grp.push_back(pairs.pop_front());
            exp_q.push_back(make_word(1'b0, grp));
        end
        if (close) exp_q.push_back(make_word(1'b1, pairs));
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit last, output int waits);
        bit taken = 0;
        bus.outmap_data = {$urandom(), $urandom(), $urandom(), $urandom()};
        bus.outmap_data[0] = b;
        bus.outmap_data_valid_num = 5'($urandom_range(1, 16));
        bus.frame_done = last;
        waits = 0;
        while (!taken && waits < 100) begin
            @(negedge clk);
            taken = (bus.valid_taken_num === 5'd1);
            waits++;
            @(posedge clk);
            #1;
            if (rand_ready) bus.rlc_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (!taken) begin
            errors++;
            $display("FAIL take_timeout byte %h waited %0d cycles", b, waits);
        end
        bus.outmap_data_valid_num = '0;
        bus.frame_done = 1'b0;
    endtask

    task automatic send_frame(input byte_q_t bytes, input bit close, output int total);
        int w;
        total = 0;
        model_push(bytes, close);
        foreach (bytes[i]) begin
            send_byte(bytes[i], close && (i == bytes.size() - 1), w);
            total += w;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            #1;
            if (rand_ready) bus.rlc_ready = 1'($urandom_range(0, 1));
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got %0d words pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.outmap_data = '0;
        bus.outmap_data_valid_num = '0;
        bus.frame_done = 1'b0;
        bus.rlc_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (bus.valid_taken_num !== 5'd0) begin errors++; $display("FAIL reset_taken got %0d expected 0", bus.valid_taken_num); end
        if (bus.rlc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", bus.rlc_valid); end
        if (bus.rlc_word !== 64'h0) begin errors++; $display("FAIL reset_word got %h expected 0", bus.rlc_word); end
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

`ifdef RLC_COMPRESSOR_STATS_EN
    task automatic test_stats();
        byte_q_t q;
        int w;
        for (int i = 0; i < 64; i++) q.push_back(8'($urandom_range(1, 255)));
        send_frame(q, 1'b0, w);
        wait_drain();
        @(negedge clk);
        checks += 2;
        if (stat_bytes_in !== 24'd64) begin errors++; $display("FAIL stat_bytes_in got %0d expected 64", stat_bytes_in); end
        if (stat_words_out !== 16'd16) begin errors++; $display("FAIL stat_words_out got %0d expected 16", stat_words_out); end
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_spec_example();
        byte_q_t q;
        int w;
        q = '{8'h05, 8'h00, 8'h00, 8'h07, 8'h09, 8'h00, 8'h03, 8'h00};
        model_push(q, 1'b1);
        for (int i = 0; i < 7; i++) send_byte(q[i], 1'b0, w);
        @(negedge clk);
        checks++;
        if (bus.rlc_valid !== 1'b1) begin errors++; $display("FAIL fill_latency valid got %b expected 1", bus.rlc_valid); end
        @(posedge clk);
        #1;
        send_byte(q[7], 1'b1, w);
        wait_drain();
    endtask

    task automatic test_long_zeros();
        byte_q_t q;
        int w;
        repeat (70) q.push_back(8'h00);
        send_frame(q, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_backpressure();
        byte_q_t q;
        int w;
        int total = 0;
        for (int i = 0; i < 12; i++) q.push_back(8'(i + 1));
        model_push(q, 1'b1);
        bus.rlc_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(q[i], 1'b0, w);
        bus.outmap_data[0] = q[4];
        bus.outmap_data_valid_num = 5'd3;
        repeat (10) begin
            @(negedge clk);
            checks += 3;
            if (bus.valid_taken_num !== 5'd0) begin errors++; $display("FAIL hold_taken got %0d expected 0", bus.valid_taken_num); end
            if (bus.rlc_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b expected 1", bus.rlc_valid); end
            if (bus.rlc_word !== exp_q[0]) begin errors++; $display("FAIL hold_word got %h expected %h", bus.rlc_word, exp_q[0]); end
            @(posedge clk);
            #1;
        end
        bus.rlc_ready = 1'b1;
        for (int i = 4; i < 12; i++) begin
            send_byte(q[i], i == 11, w);
            total += w;
        end
        checks++;
        if (total !== 8) begin errors++; $display("FAIL resume_rate got %0d cycles expected 8", total); end
        wait_drain();
    endtask

    task automatic test_back_to_back();
        byte_q_t q;
        int total;
        for (int i = 0; i < 16; i++) q.push_back(8'($urandom_range(1, 255)));
        send_frame(q, 1'b1, total);
        checks++;
        if (total !== 16) begin errors++; $display("FAIL b2b_rate got %0d cycles expected 16", total); end
        wait_drain();
    endtask

    task automatic test_single_byte_frame();
        byte_q_t q;
        int w;
        q = '{8'h11};
        send_frame(q, 1'b1, w);
        q = '{8'h12, 8'h00, 8'h13};
        model_push(q, 1'b1);
        send_byte(q[0], 1'b0, w);
        checks++;
        if (w !== 3) begin errors++; $display("FAIL flush_to_active got %0d cycles expected 3", w); end
        send_byte(q[1], 1'b0, w);
        send_byte(q[2], 1'b1, w);
        wait_drain();
    endtask

    task automatic test_full_then_empty();
        byte_q_t q;
        int w;
        q = '{8'h01, 8'h02, 8'h03, 8'h04};
        send_frame(q, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_frame_done_ignored();
        byte_q_t q;
        int w;
        bus.frame_done = 1'b1;
        bus.outmap_data_valid_num = '0;
        repeat (5) begin
            @(negedge clk);
            checks += 2;
            if (bus.valid_taken_num !== 5'd0) begin errors++; $display("FAIL idle_taken got %0d expected 0", bus.valid_taken_num); end
            if (bus.rlc_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b expected 0", bus.rlc_valid); end
            @(posedge clk);
            #1;
        end
        bus.frame_done = 1'b0;
        q = '{8'h44, 8'h00, 8'h55};
        send_frame(q, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_reset_midframe();
        byte_q_t q;
        int w;
        send_byte(8'h21, 1'b0, w);
        send_byte(8'h22, 1'b0, w);
        send_byte(8'h00, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (bus.valid_taken_num !== 5'd0) begin errors++; $display("FAIL midrst_taken got %0d expected 0", bus.valid_taken_num); end
        if (bus.rlc_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b expected 0", bus.rlc_valid); end
        if (bus.rlc_word !== 64'h0) begin errors++; $display("FAIL midrst_word got %h expected 0", bus.rlc_word); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        q = '{8'h31, 8'h00, 8'h32, 8'h33};
        send_frame(q, 1'b1, w);
        wait_drain();
    endtask

    task automatic test_random_stream();
        byte_q_t q;
        int w;
        for (int i = 0; i < 200; i++) begin
            if (i >= 120 && i < 160) q.push_back(8'h00);
            else if ($urandom_range(0, 9) < 6) q.push_back(8'h00);
            else q.push_back(8'($urandom_range(1, 255)));
        end
        rand_ready = 1;
        send_frame(q, 1'b1, w);
        rand_ready = 0;
        bus.rlc_ready = 1'b1;
        wait_drain();
    endtask

    initial begin
        test_reset();
`ifdef RLC_COMPRESSOR_STATS_EN
        test_stats();
`endif
        test_spec_example();
        test_long_zeros();
        test_backpressure();
        test_back_to_back();
        test_single_byte_frame();
        test_full_then_empty();
        test_frame_done_ignored();
        test_reset_midframe();
        test_random_stream();
        repeat (5) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_words got %0d expected 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
